sig_compactor: RTL and testbench

SIG_COMPACTOR -- requirements
Module: sig_compactor

---
 rtl/sig_compactor.sv | 121 ++++++++++++
 tb/tb_sig_compactor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_compactor.sv
// Signature compactor: MISR-style compaction of a parallel response stream over a
// fixed window, golden compare at window end, and a serial scan path through the register.
module sig_compactor #(
  parameter int unsigned     NBIT   = 8,
  parameter int unsigned     NIN    = 5,
  parameter logic [NBIT-1:0] POLY   = NBIT'(8'h1D),
  parameter logic [NBIT-1:0] SEED   = '1,
  parameter int unsigned     WINDOW = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            valid,
  input  logic [NIN-1:0]  data_in,
  input  logic            scan_en,
  input  logic            scan_in,
  input  logic [NBIT-1:0] golden,
  output logic [NBIT-1:0] signature,
  output logic            scan_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [15:0]     cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, SCAN} state_t;

  state_t          state, state_nx;
  logic [NBIT-1:0] sig, sig_nx;
  logic [15:0]     cnt, cnt_nx;
  logic            busy_r, busy_nx;
  logic            done_r, done_nx;
  logic            pass_r, pass_nx;
  logic            fail_r, fail_nx;

  logic [NBIT-1:0] step;
  logic [NBIT-1:0] shifted;
  logic            last_valid;

  assign step       = {sig[NBIT-2:0], 1'b0} ^ (POLY & {NBIT{sig[NBIT-1]}}) ^ NBIT'(data_in);
  assign shifted    = {sig[NBIT-2:0], scan_in};
  assign last_valid = (cnt == 16'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sig    <= SEED;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
    end else begin
      state  <= state_nx;
      sig    <= sig_nx;
      cnt    <= cnt_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
      pass_r <= pass_nx;
      fail_r <= fail_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sig_nx   = sig;
    cnt_nx   = cnt;
    busy_nx  = busy_r;
    done_nx  = done_r;
    pass_nx  = pass_r;
    fail_nx  = fail_r;

    if (start) begin
      state_nx = RUN;
      sig_nx   = SEED;
      cnt_nx   = '0;
      busy_nx  = 1'b1;
      done_nx  = 1'b0;
      pass_nx  = 1'b0;
      fail_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (scan_en) begin
            state_nx = SCAN;
            sig_nx   = shifted;
          end
        end
        RUN: begin
          if (valid) begin
            sig_nx = step;
            cnt_nx = 16'(cnt + 16'd1);
            // Golden compare uses the post-step value so the verdict lands with done.
            if (last_valid) begin
              state_nx = DONE;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
              pass_nx  = (step == golden);
              fail_nx  = (step != golden);
            end
          end
        end
        SCAN: begin
          if (scan_en) sig_nx = shifted;
          else         state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign signature = sig;
  assign scan_out  = sig[NBIT-1];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign cycle_cnt = cnt;

endmodule

// File: tb/tb_sig_compactor.sv
// Bench for sig_compactor: directed scenarios plus randomized traffic against a
// transaction-level reference model, on a default instance and a WINDOW=4 instance.
module tb_sig_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, valid, scan_en, scan_in;
  logic [4:0] data_in;
  logic [7:0] golden;

  logic [7:0]  sig_a, sig_b;
  logic        so_a, so_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, fail_a, fail_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  sig_compactor dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .data_in(data_in),
    .scan_en(scan_en), .scan_in(scan_in), .golden(golden),
    .signature(sig_a), .scan_out(so_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .cycle_cnt(cnt_a)
  );

  sig_compactor #(.WINDOW(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .data_in(data_in),
    .scan_en(scan_en), .scan_in(scan_in), .golden(golden),
    .signature(sig_b), .scan_out(so_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .cycle_cnt(cnt_b)
  );

  // Reference model: mode 0 idle, 1 running, 2 finished, 3 scanning.
  typedef struct {
    int         mode;
    logic [7:0] sig;
    int         cnt;
    bit         busy, done, pass, fail;
  } mdl_t;

  mdl_t m1, m4;

  function automatic logic [7:0] lfsr(input logic [7:0] s, input logic [4:0] d);
    int v;
    v = int'(s) * 2;
    if (v > 255) v = (v - 256) ^ 'h1D;
    return 8'(v) ^ {3'b000, d};
  endfunction

  function automatic mdl_t next_mdl(input mdl_t m, input int window);
    mdl_t n;
    n = m;
    if (rst) begin
      n.mode = 0; n.sig = 8'hFF; n.cnt = 0;
      n.busy = 0; n.done = 0; n.pass = 0; n.fail = 0;
    end else if (start) begin
      n.mode = 1; n.sig = 8'hFF; n.cnt = 0;
      n.busy = 1; n.done = 0; n.pass = 0; n.fail = 0;
    end else if (m.mode == 1) begin
      if (valid) begin
        n.sig = lfsr(m.sig, data_in);
        n.cnt = m.cnt + 1;
        if (n.cnt == window) begin
          n.mode = 2; n.busy = 0; n.done = 1;
          n.pass = (n.sig == golden); n.fail = !n.pass;
        end
      end
    end else if (scan_en) begin
      n.mode = 3;
      n.sig  = 8'((int'(m.sig) * 2 + int'(scan_in)) % 256);
    end else if (m.mode == 3) begin
      n.mode = 0;
    end
    return n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    m1 = next_mdl(m1, 256);
    m4 = next_mdl(m4, 4);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); rst = 0;
    checks++;
    if ({sig_a, cnt_a, so_a, busy_a, done_a, pass_a, fail_a} !== {8'hFF, 16'd0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL reset got sig=%h cnt=%0d so=%b bdpf=%b%b%b%b exp sig=ff cnt=0 so=1 bdpf=0000",
               sig_a, cnt_a, so_a, busy_a, done_a, pass_a, fail_a);
    end
    checks++;
    if ({sig_b, cnt_b, busy_b, done_b, pass_b, fail_b} !== {8'hFF, 16'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_w4 got sig=%h cnt=%0d exp sig=ff cnt=0", sig_b, cnt_b);
    end
  endtask

  task automatic test_vectors();
    start = 1; cyc(); start = 0;
    valid = 1; data_in = 5'h00; cyc(); valid = 0;
    checks++;
    if ({sig_a, cnt_a, busy_a} !== {8'hE3, 16'd1, 1'b1}) begin
      failures++;
      $display("FAIL vec_one got sig=%h cnt=%0d busy=%b exp sig=e3 cnt=1 busy=1", sig_a, cnt_a, busy_a);
    end
    cyc();
    checks++;
    if ({sig_a, cnt_a} !== {8'hE3, 16'd1}) begin
      failures++;
      $display("FAIL vec_hold got sig=%h cnt=%0d exp sig=e3 cnt=1", sig_a, cnt_a);
    end
    valid = 1; cyc(); valid = 0;
    checks++;
    if ({sig_a, cnt_a} !== {8'hDB, 16'd2}) begin
      failures++;
      $display("FAIL vec_two got sig=%h cnt=%0d exp sig=db cnt=2", sig_a, cnt_a);
    end
    start = 1; cyc(); start = 0;
    valid = 1; data_in = 5'h01; cyc(); valid = 0;
    checks++;
    if ({sig_a, cnt_a} !== {8'hE2, 16'd1}) begin
      failures++;
      $display("FAIL vec_data got sig=%h cnt=%0d exp sig=e2 cnt=1", sig_a, cnt_a);
    end
  endtask

  task automatic test_window();
    logic [4:0] d [4];
    logic [7:0] exp_sig;
    for (int r = 0; r < 2; r++) begin
      exp_sig = 8'hFF;
      for (int k = 0; k < 4; k++) begin
        d[k] = 5'($urandom);
        exp_sig = lfsr(exp_sig, d[k]);
      end
      golden = (r == 0) ? exp_sig : (exp_sig ^ 8'h01);
      start = 1; cyc(); start = 0;
      for (int k = 0; k < 4; k++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          valid = 0; data_in = 5'($urandom); cyc();
          checks++;
          if ({done_b, cnt_b} !== {1'b0, 16'(k)}) begin
            failures++;
            $display("FAIL win_gap got done=%b cnt=%0d exp done=0 cnt=%0d", done_b, cnt_b, k);
          end
        end
        valid = 1; data_in = d[k]; cyc(); valid = 0;
        if (k < 3) begin
          checks++;
          if ({done_b, busy_b, cnt_b} !== {2'b01, 16'(k + 1)}) begin
            failures++;
            $display("FAIL win_early got done=%b busy=%b cnt=%0d exp done=0 busy=1 cnt=%0d",
                     done_b, busy_b, cnt_b, k + 1);
          end
        end
      end
      checks++;
      if ({sig_b, cnt_b, busy_b, done_b, pass_b, fail_b} !==
          {exp_sig, 16'd4, 2'b01, (r == 0), (r != 0)}) begin
        failures++;
        $display("FAIL win_end run=%0d got sig=%h cnt=%0d bdpf=%b%b%b%b exp sig=%h cnt=4 pass=%0d",
                 r, sig_b, cnt_b, busy_b, done_b, pass_b, fail_b, exp_sig, r == 0);
      end
      for (int h = 0; h < 3; h++) begin
        valid = 1; data_in = 5'($urandom); cyc();
      end
      valid = 0;
      checks++;
      if ({sig_b, cnt_b, done_b, pass_b, fail_b} !== {exp_sig, 16'd4, 1'b1, (r == 0), (r != 0)}) begin
        failures++;
        $display("FAIL win_hold got sig=%h cnt=%0d exp sig=%h cnt=4", sig_b, cnt_b, exp_sig);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] pat;
    pat = 8'hA5;
    scan_en = 1;
    for (int i = 7; i >= 0; i--) begin
      scan_in = pat[i]; cyc();
    end
    checks++;
    if ({sig_b, done_b, pass_b, fail_b, busy_b} !== {8'hA5, 4'b1010}) begin
      failures++;
      $display("FAIL scan_load got sig=%h dpfb=%b%b%b%b exp sig=a5 dpfb=1010",
               sig_b, done_b, pass_b, fail_b, busy_b);
    end
    scan_in = 0;
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (so_b !== pat[i]) begin
        failures++;
        $display("FAIL scan_out bit=%0d got=%b exp=%b", 7 - i, so_b, pat[i]);
      end
      cyc();
    end
    checks++;
    if (sig_b !== 8'h00) begin
      failures++;
      $display("FAIL scan_final got=%h exp=00", sig_b);
    end
    scan_en = 0; cyc();
    valid = 1; data_in = 5'h1F; cyc(); valid = 0;
    checks++;
    if ({sig_b, busy_b, cnt_b} !== {8'h00, 1'b0, 16'd4}) begin
      failures++;
      $display("FAIL scan_exit got sig=%h busy=%b cnt=%0d exp sig=00 busy=0 cnt=4", sig_b, busy_b, cnt_b);
    end
  endtask

  task automatic test_priority();
    start = 1; cyc(); start = 0;
    valid = 1;
    for (int k = 0; k < 3; k++) begin
      data_in = 5'($urandom); cyc();
    end
    checks++;
    if (cnt_a !== 16'd3) begin
      failures++;
      $display("FAIL pri_pre got cnt=%0d exp=3", cnt_a);
    end
    rst = 1; start = 1; scan_en = 1; cyc(); rst = 0; start = 0; scan_en = 0; valid = 0;
    checks++;
    if ({sig_a, cnt_a, busy_a} !== {8'hFF, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL pri_rst got sig=%h cnt=%0d busy=%b exp sig=ff cnt=0 busy=0", sig_a, cnt_a, busy_a);
    end
    start = 1; scan_en = 1; scan_in = 0; cyc(); start = 0;
    checks++;
    if ({sig_a, cnt_a, busy_a} !== {8'hFF, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL pri_start got sig=%h cnt=%0d busy=%b exp sig=ff cnt=0 busy=1", sig_a, cnt_a, busy_a);
    end
    valid = 1; data_in = 5'h00; cyc();
    checks++;
    if ({sig_a, cnt_a} !== {8'hE3, 16'd1}) begin
      failures++;
      $display("FAIL pri_run_noscan got sig=%h cnt=%0d exp sig=e3 cnt=1", sig_a, cnt_a);
    end
    data_in = 5'h0A; cyc();
    start = 1; cyc(); start = 0; valid = 0; scan_en = 0;
    checks++;
    if ({sig_a, cnt_a, busy_a} !== {8'hFF, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL restart got sig=%h cnt=%0d exp sig=ff cnt=0", sig_a, cnt_a);
    end
    rst = 1; cyc(); rst = 0;
    scan_en = 1; scan_in = 0; cyc(); cyc();
    rst = 1; cyc(); rst = 0; scan_en = 0;
    checks++;
    if (sig_a !== 8'hFF) begin
      failures++;
      $display("FAIL rst_scan got sig=%h exp=ff", sig_a);
    end
  endtask

  task automatic test_random();
    bit scan_on = 0;
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 1499) == 0);
      start   = ($urandom_range(0, 399) == 0);
      valid   = ($urandom_range(0, 3) != 0);
      data_in = 5'($urandom);
      if ($urandom_range(0, 19) == 0) scan_on = !scan_on;
      scan_en = scan_on;
      scan_in = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       golden = lfsr(m1.sig, data_in);
        1:       golden = lfsr(m4.sig, data_in);
        default: golden = 8'($urandom);
      endcase
      cyc();
      checks++;
      if ({sig_a, cnt_a, busy_a, done_a, pass_a, fail_a, so_a} !==
          {m1.sig, 16'(m1.cnt), m1.busy, m1.done, m1.pass, m1.fail, m1.sig[7]}) begin
        failures++;
        $display("FAIL rand_dflt cyc=%0d got sig=%h cnt=%0d bdpf=%b%b%b%b exp sig=%h cnt=%0d bdpf=%b%b%b%b",
                 c, sig_a, cnt_a, busy_a, done_a, pass_a, fail_a,
                 m1.sig, m1.cnt, m1.busy, m1.done, m1.pass, m1.fail);
      end
      checks++;
      if ({sig_b, cnt_b, busy_b, done_b, pass_b, fail_b, so_b} !==
          {m4.sig, 16'(m4.cnt), m4.busy, m4.done, m4.pass, m4.fail, m4.sig[7]}) begin
        failures++;
        $display("FAIL rand_w4 cyc=%0d got sig=%h cnt=%0d bdpf=%b%b%b%b exp sig=%h cnt=%0d bdpf=%b%b%b%b",
                 c, sig_b, cnt_b, busy_b, done_b, pass_b, fail_b,
                 m4.sig, m4.cnt, m4.busy, m4.done, m4.pass, m4.fail);
      end
    end
    rst = 0; start = 0; valid = 0; scan_en = 0;
  endtask

  initial begin
    rst = 0; start = 0; valid = 0; scan_en = 0; scan_in = 0;
    data_in = '0; golden = '0;
    m1 = '{mode: 0, sig: 8'hFF, cnt: 0, busy: 0, done: 0, pass: 0, fail: 0};
    m4 = m1;
    test_reset();
    test_vectors();
    test_window();
    test_scan();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
